// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue with single-outstanding fetch FSM
//
// Purpose:
//   Issues word-aligned fetch requests to instruction memory, one at a time,
//   and buffers the returned {pc, inst} pairs in a DEPTH-entry circular FIFO.
//   A redirect flushes the queue and restarts fetching at the new target; a
//   response that is still in flight when a redirect arrives is dropped.
//
// Optional feature:
//   IFQ_BYPASS_EN - when defined, a response arriving while the queue is empty
//   is presented on inst_* in the same cycle and is not enqueued if consumed.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   imem_req, imem_addr     - fetch request and word-aligned address
//   imem_ack, imem_rdata    - request completion and fetched word
//   redirect, redirect_pc   - flush and refetch from redirect_pc
//   inst_ready              - consumer accepts the head entry
//   inst_valid, inst_out,   - head entry valid, instruction, and its PC
//   pc_out                    (both zero when inst_valid is low)
//   count                   - current queue occupancy

module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     inst_ready,
   output logic                     inst_valid,
   output logic [31:0]              inst_out,
   output logic [31:0]              pc_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     pc_mem_q   [DEPTH];
   logic [31:0]     pc_mem_d   [DEPTH];
   logic [31:0]     inst_mem_q [DEPTH];
   logic [31:0]     inst_mem_d [DEPTH];

   logic            head_valid;
   logic            pop;
   logic            push;
   logic            consumed_direct;
   logic [CW-1:0]   occ_after_pop;
   logic [31:0]     redirect_aligned;
   logic [31:0]     addr_sel;

   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
   assign head_valid       = (count_q != '0);
   assign count            = count_q;

   // In IDLE the address shows where the next fetch will go; once a request
   // is launched the latched address is held, so a redirect during DROP does
   // not disturb the outstanding bus transaction.
   assign addr_sel  = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
   assign imem_addr = addr_sel & 32'hFFFF_FFFC;
   assign imem_req  = (state_q == REQ) || (state_q == DROP);

   // Head presentation, optionally overridden by the same-cycle bypass.
   always_comb begin
      inst_valid      = head_valid;
      inst_out        = head_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
      pc_out          = head_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
      consumed_direct = 1'b0;
`ifdef IFQ_BYPASS_EN
      if (!head_valid && (state_q == REQ) && imem_ack && !redirect) begin
         inst_valid      = 1'b1;
         inst_out        = imem_rdata;
         pc_out          = fetch_pc_q;
         consumed_direct = inst_ready;
      end
`endif
   end

   // pop only ever drains a stored entry; a bypassed word is never stored.
   assign pop  = head_valid && inst_ready;
   assign push = (state_q == REQ) && imem_ack && !redirect && !consumed_direct;

   assign occ_after_pop = count_q - CW'(pop);

   // Fetch FSM and fetch_pc sequencing.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;

      case (state_q)
         IDLE: begin
            // A request is only launched when a slot is guaranteed free, so
            // the eventual push can never land on a full queue.
            if (redirect) begin
               state_d    = REQ;
               req_addr_d = redirect_aligned;
            end else if (occ_after_pop < CW'(DEPTH)) begin
               state_d    = REQ;
               req_addr_d = fetch_pc_q;
            end
         end
         REQ: begin
            if (imem_ack) begin
               state_d = IDLE;
               if (!redirect) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect) begin
         fetch_pc_d = redirect_aligned;
      end
   end

   // Queue pointers, occupancy and storage.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]   = fetch_pc_q;
            inst_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d             = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
         req_addr_q <= RESET_PC & 32'hFFFF_FFFC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: every read is qualified by count.
   always_ff @(posedge clk) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue

module tb_ifetch_queue;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [2:0]  count;

   logic        use_auto;
   logic [31:0] rdata_man;

   int n_cmp;
   int n_err;

   localparam logic [31:0] TAGK = 32'hA5A5_0000;

   // Memory model: the word at address A is A ^ TAGK unless overridden.
   assign imem_rdata = use_auto ? (imem_addr ^ TAGK) : rdata_man;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_ready  (inst_ready),
      .inst_valid  (inst_valid),
      .inst_out    (inst_out),
      .pc_out      (pc_out),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Leaves the bench in the first cycle after reset deasserts plus one,
   // i.e. the cycle in which the first request must be on the bus.
   task automatic do_reset();
      reset       = 1'b1;
      imem_ack    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b0;
      use_auto    = 1'b1;
      rdata_man   = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset       = 1'b1;
      imem_ack    = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b1;
      use_auto    = 1'b1;
      rdata_man   = 32'h0;

      // Reset state, with ack asserted to show it is ignored under reset.
      tick();
      tick();
      chk("rst_req",   32'(imem_req),   32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst",  inst_out,        32'h0);
      chk("rst_pc",    pc_out,          32'h0);
      chk("rst_count", 32'(count),      32'h0);

      // Streaming: ack tied high, consumer always ready.
      do_reset();
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      chk("first_req",  32'(imem_req), 32'h1);
      chk("first_addr", imem_addr,     32'h0);
`ifndef IFQ_BYPASS_EN
      chk("no_comb_path", 32'(inst_valid), 32'h0);
`endif
      for (int i = 0; i < 4; i++) begin
         chk("stream_addr", imem_addr,     32'(4 * i));
         chk("stream_req",  32'(imem_req), 32'h1);
         tick();
         chk("stream_valid", 32'(inst_valid), 32'h1);
         chk("stream_pc",    pc_out,          32'(4 * i));
         chk("stream_inst",  inst_out,        32'(4 * i) ^ TAGK);
         tick();
      end

      // Saturation: consumer stalled, queue fills to DEPTH and fetch stops.
      do_reset();
      imem_ack   = 1'b1;
      inst_ready = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("sat_count", 32'(count),      32'h4);
      chk("sat_req",   32'(imem_req),   32'h0);
      chk("sat_valid", 32'(inst_valid), 32'h1);
      chk("sat_pc",    pc_out,          32'h0);
      tick();
      tick();
      chk("sat_hold_count", 32'(count),    32'h4);
      chk("sat_hold_req",   32'(imem_req), 32'h0);
      chk("sat_hold_inst",  inst_out,      32'h0 ^ TAGK);
      inst_ready = 1'b1;
      chk("drain_pc0", pc_out, 32'h0);
      tick();
      chk("drain_pc1", pc_out, 32'h4);
      tick();
      chk("drain_pc2", pc_out, 32'h8);
      tick();
      chk("drain_pc3",   pc_out,   32'hC);
      chk("drain_inst3", inst_out, 32'hC ^ TAGK);

      // Redirect while waiting on a slow response: stale word is dropped.
      do_reset();
      imem_ack   = 1'b0;
      inst_ready = 1'b1;
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      chk("drop_req",   32'(imem_req), 32'h1);
      chk("drop_addr",  imem_addr,     32'h0);
      chk("drop_count", 32'(count),    32'h0);
      use_auto  = 1'b0;
      rdata_man = 32'hDEAD_BEEF;
      imem_ack  = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("drop_after_count", 32'(count),      32'h0);
      chk("drop_after_valid", 32'(inst_valid), 32'h0);
      chk("drop_after_req",   32'(imem_req),   32'h0);
      tick();
      chk("redir_req",  32'(imem_req), 32'h1);
      chk("redir_addr", imem_addr,     32'h0000_0100);

      // Redirect coinciding with ack while two entries are queued.
      do_reset();
      imem_ack   = 1'b1;
      inst_ready = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("pre_redir_count", 32'(count), 32'h2);
      chk("pre_redir_addr",  imem_addr,  32'h8);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      chk("same_count", 32'(count),      32'h0);
      chk("same_valid", 32'(inst_valid), 32'h0);
      chk("same_req",   32'(imem_req),   32'h0);
      tick();
      chk("same_next_req",  32'(imem_req), 32'h1);
      chk("same_next_addr", imem_addr,     32'h0000_0200);
      tick();
      chk("same_head_pc",   pc_out,   32'h0000_0200);
      chk("same_head_inst", inst_out, 32'h0000_0200 ^ TAGK);

      // Address wrap at the top of the address space.
      do_reset();
      inst_ready  = 1'b1;
      imem_ack    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      tick();
      chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_head_pc", pc_out, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr_zero", imem_addr,     32'h0);
      chk("wrap_req",       32'(imem_req), 32'h1);

      // Reset while a request is outstanding; late ack in IDLE is ignored.
      do_reset();
      imem_ack = 1'b0;
      reset    = 1'b1;
      tick();
      reset     = 1'b0;
      use_auto  = 1'b0;
      rdata_man = 32'h1234_5678;
      imem_ack  = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("late_ack_count", 32'(count),      32'h0);
      chk("late_ack_valid", 32'(inst_valid), 32'h0);
      chk("late_ack_req",   32'(imem_req),   32'h1);
      chk("late_ack_addr",  imem_addr,       32'h0);

      // Response to an empty queue: bypassed when enabled, queued otherwise.
      do_reset();
      use_auto   = 1'b0;
      rdata_man  = 32'h0010_0093;
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      #1;
`ifdef IFQ_BYPASS_EN
      chk("byp_valid", 32'(inst_valid), 32'h1);
      chk("byp_inst",  inst_out,        32'h0010_0093);
      chk("byp_pc",    pc_out,          32'h0);
      tick();
      imem_ack = 1'b0;
      chk("byp_count", 32'(count), 32'h0);
`else
      chk("nobyp_valid", 32'(inst_valid), 32'h0);
      chk("nobyp_inst",  inst_out,        32'h0);
      tick();
      imem_ack = 1'b0;
      chk("nobyp_count",   32'(count),      32'h1);
      chk("nobyp_valid_n", 32'(inst_valid), 32'h1);
      chk("nobyp_inst_n",  inst_out,        32'h0010_0093);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
